// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM state encoding and the
// {pc, instruction} record held in the instruction queue.
package fetch_pkg;

  localparam int PKG_ADDRESS_WIDTH     = 64;
  localparam int PKG_INSTRUCTION_WIDTH = 32;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    SQUASH
  } fetch_state_t;

  typedef struct packed {
    logic [PKG_ADDRESS_WIDTH-1:0]     pc;
    logic [PKG_INSTRUCTION_WIDTH-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries. Flush beats push/pop; storage is cleared
// only by reset so the head reads as zero straight out of reset.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               push,
  input  fetch_entry_t                       push_entry,
  input  logic                               pop,
  output fetch_entry_t                       head,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(QUEUE_DEPTH);

  fetch_entry_t      mem [QUEUE_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding icache read, responses queued for
// decode, redirects flush the queue and squash an in-flight response.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH     = 64,
  parameter int                       INSTRUCTION_WIDTH = 32,
  parameter int                       QUEUE_DEPTH       = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC          = '0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0]            in_redirect_target,
  output logic                                icache_req_valid,
  output logic [ADDRESS_WIDTH-1:0]            icache_req_addr,
  input  logic                                icache_req_ready,
  input  logic                                icache_resp_valid,
  input  logic [INSTRUCTION_WIDTH-1:0]        icache_resp_data,
  output logic                                out_valid,
  output logic [INSTRUCTION_WIDTH-1:0]        out_instruction_bits,
  output logic [ADDRESS_WIDTH-1:0]            out_pc,
  output logic [ADDRESS_WIDTH-1:0]            out_pcplus4,
  input  logic                                in_decode_ready,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]    out_queue_count
);

  localparam int             CW      = $clog2(QUEUE_DEPTH+1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(QUEUE_DEPTH);

  fetch_state_t               state, state_next;
  logic [ADDRESS_WIDTH-1:0]   fetch_pc;
  logic [ADDRESS_WIDTH-1:0]   req_pc;
  logic [ADDRESS_WIDTH-1:0]   redirect_pc;
  logic                       handshake, push, pop;
  fetch_entry_t               push_entry, head;

  assign redirect_pc      = in_redirect_target & ~ADDRESS_WIDTH'(3);
  assign icache_req_valid = !reset && (state == FETCH) &&
                            (out_queue_count < DEPTH_C) && !in_redirect_valid;
  assign icache_req_addr  = fetch_pc;
  assign handshake        = icache_req_valid && icache_req_ready;

  // A redirect suppresses both queue ports; the flush takes effect instead.
  assign push       = (state == WAIT) && icache_resp_valid && !in_redirect_valid;
  assign pop        = out_valid && in_decode_ready && !in_redirect_valid;
  assign push_entry = '{pc: req_pc, instruction: icache_resp_data};

  assign out_valid            = (out_queue_count != '0);
  assign out_pc               = head.pc;
  assign out_instruction_bits = head.instruction;
  assign out_pcplus4          = head.pc + ADDRESS_WIDTH'(4);

  always_comb begin
    state_next = state;
    unique case (state)
      FETCH:   if (handshake) state_next = WAIT;
      WAIT: begin
        if (icache_resp_valid)      state_next = FETCH;
        else if (in_redirect_valid) state_next = SQUASH;
      end
      SQUASH:  if (icache_resp_valid) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_next;
      if (in_redirect_valid) fetch_pc <= redirect_pc;
      else if (push)         fetch_pc <= req_pc + ADDRESS_WIDTH'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (handshake) req_pc <= fetch_pc;
  end

  fetch_queue #(
    .QUEUE_DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (in_redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (out_queue_count)
  );

endmodule
